// File: rtl/uart_tx_baud_pkg.sv
// uart_tx_baud_pkg: FSM state encoding and parity codes shared by the UART transmitter files
package uart_tx_baud_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_DATA, S_PAR, S_STOP} state_e;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
endpackage

// File: rtl/uart_tx_baud_edge.sv
// uart_tx_baud_edge: synchronizes the divided baud wave and emits a one-cycle tick per rising edge
module uart_tx_baud_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic baud_in,
  output logic tick_o
);
  logic [2:0] s_q;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) s_q <= '0;
    else     s_q <= {s_q[1:0], baud_in};
  assign tick_o = s_q[1] & ~s_q[2];
endmodule

// File: rtl/uart_tx_baud.sv
// uart_tx_baud: serial transmitter clocked by baud ticks, start/data/parity/stop, LSB first
module uart_tx_baud
  import uart_tx_baud_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 ready,
  output logic                 tx
);
  localparam int CW = $clog2(DATA_BITS);
  localparam bit HAS_PAR = PARITY != PAR_NONE;
  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tx_q, tx_d, ready_q, ready_d, par_q, par_d, tick;
  uart_tx_baud_edge u_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .baud_in(baud_in),
    .tick_o (tick)
  );
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      par_q   <= par_d;
    end
  // cnt indexes data bits in DATA and counts stop-bit ticks in STOP
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: if (start && ready_q) begin
        sh_d    = data;
        par_d   = (PARITY == PAR_EVEN) ? ^data : ~^data;
        ready_d = 1'b0;
        state_d = S_ARM;
      end
      S_ARM: if (tick) begin
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: if (tick) begin
        tx_d    = sh_q[0];
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (tick) begin
        if (cnt_q == CW'(DATA_BITS - 1)) begin
          tx_d    = HAS_PAR ? par_q : 1'b1;
          cnt_d   = '0;
          state_d = HAS_PAR ? S_PAR : S_STOP;
        end else begin
          tx_d  = sh_q[1];
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAR: if (tick) begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        if (cnt_q == CW'(STOP_BITS - 1)) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign ready = ready_q;
  assign tx    = tx_q;
endmodule
